// File: rtl/pri_dec.sv
// Registered binary-to-one-hot decoder with a valid/ready handshake and a 2-entry skid buffer.
// Codes are decoded on acceptance, so both buffer entries hold ready-to-present vectors.
module pri_dec #(
   parameter int W     = 2,
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [W-1:0]         in_code,
   input  logic                 in_zero,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [(1<<W)-1:0]    out_onehot,
   output logic                 out_zero,
   output logic [CNT_W-1:0]     out_cnt
);

   localparam int N = 1 << W;

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   state_t             state_p1;
   state_t             state_nx;
   logic [N-1:0]       m_vec_p1;
   logic               m_zero_p1;
   logic [N-1:0]       s_vec_p1;
   logic               s_zero_p1;
   logic               rdy_p1;
   logic [CNT_W-1:0]   cnt_p1;

   logic               acc;
   logic               dlv;
   logic               ld_m_in;
   logic               ld_m_skid;
   logic               ld_s;
   logic [N-1:0]       dec_vec;

   function automatic logic [N-1:0] decode(input logic [W-1:0] code, input logic zero);
      logic [N-1:0] v;
      v = '0;
      if (!zero)
         v[code] = 1'b1;
      return v;
   endfunction

   assign acc     = in_valid & rdy_p1;
   assign dlv     = out_valid & out_ready;
   assign dec_vec = decode(in_code, in_zero);

   // State register; in_ready is registered from the next state so it never sees out_ready combinationally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_p1 <= EMPTY;
         rdy_p1   <= 1'b1;
      end else begin
         state_p1 <= state_nx;
         rdy_p1   <= (state_nx != FULL);
      end
   end

   always_comb begin
      state_nx = state_p1;
      unique case (state_p1)
         EMPTY: if (acc) state_nx = ONE;
         ONE: begin
            if (acc && !dlv)
               state_nx = FULL;
            else if (!acc && dlv)
               state_nx = EMPTY;
         end
         FULL:    if (dlv) state_nx = ONE;
         default: state_nx = EMPTY;
      endcase
   end

   always_comb begin
      out_valid  = (state_p1 != EMPTY);
      in_ready   = rdy_p1;
      out_onehot = m_vec_p1;
      out_zero   = m_zero_p1;
      out_cnt    = cnt_p1;
      ld_m_in    = acc && ((state_p1 == EMPTY) || ((state_p1 == ONE) && out_ready));
      ld_s       = acc && (state_p1 == ONE) && !out_ready;
      ld_m_skid  = (state_p1 == FULL) && out_ready;
   end

   // Main and skid entries plus the delivery counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_vec_p1  <= '0;
         m_zero_p1 <= 1'b0;
         s_vec_p1  <= '0;
         s_zero_p1 <= 1'b0;
         cnt_p1    <= '0;
      end else begin
         if (ld_m_in) begin
            m_vec_p1  <= dec_vec;
            m_zero_p1 <= in_zero;
         end else if (ld_m_skid) begin
            m_vec_p1  <= s_vec_p1;
            m_zero_p1 <= s_zero_p1;
         end
         if (ld_s) begin
            s_vec_p1  <= dec_vec;
            s_zero_p1 <= in_zero;
         end
         if (dlv)
            cnt_p1 <= cnt_p1 + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pri_dec.sv
// Directed bench for pri_dec (W=2, CNT_W=8): reset, streaming, back-pressure, counter wrap, encoder loopback.
module tb_pri_dec;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] in_code;
   logic       in_zero;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_onehot;
   logic       out_zero;
   logic [7:0] out_cnt;

   int checks = 0;
   int errors = 0;

   pri_dec #(.W(2), .CNT_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_code    (in_code),
      .in_zero    (in_zero),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_onehot (out_onehot),
      .out_zero   (out_zero),
      .out_cnt    (out_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference 4-to-2 priority encoder (highest set bit wins)
   function automatic logic [2:0] enc(input logic [3:0] a);
      logic [1:0] c;
      c = 2'd0;
      for (int b = 0; b < 4; b++)
         if (a[b]) c = b[1:0];
      return {(a == 4'd0), c};
   endfunction

   function automatic logic [3:0] top_bit(input logic [3:0] a);
      if (a >= 4'd8) return 4'b1000;
      if (a >= 4'd4) return 4'b0100;
      if (a >= 4'd2) return 4'b0010;
      if (a >= 4'd1) return 4'b0001;
      return 4'b0000;
   endfunction

   logic [4:0] q[$];
   logic       acc, dlv;
   logic [4:0] front;
   logic [2:0] e;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_code = 2'd0; in_zero = 1'b0; out_ready = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // T1 reset values
      check("t1_valid", out_valid, 0);
      check("t1_onehot", out_onehot, 4'b0000);
      check("t1_ready", in_ready, 1);
      check("t1_cnt", out_cnt, 0);
      check("t1_zero", out_zero, 0);

      // T2 streaming at full rate
      out_ready = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_code = i[1:0]; in_zero = 1'b0;
         tick();
         check("t2_valid", out_valid, 1);
         check("t2_onehot", out_onehot, 32'(4'b0001 << i));
         check("t2_zero", out_zero, 0);
      end
      in_code = 2'd3; in_zero = 1'b1;
      tick();
      check("t2_zvec", out_onehot, 4'b0000);
      check("t2_zflag", out_zero, 1);
      check("t2_zvalid", out_valid, 1);
      in_valid = 1'b0; in_zero = 1'b0;
      tick();
      check("t2_empty", out_valid, 0);
      check("t2_cnt", out_cnt, 5);

      // T3 back-pressure fills the skid entry
      out_ready = 1'b0; in_valid = 1'b1; in_code = 2'd2;
      tick();
      check("t3_first", out_onehot, 4'b0100);
      check("t3_rdy1", in_ready, 1);
      in_code = 2'd1;
      tick();
      check("t3_full_rdy", in_ready, 0);
      check("t3_hold", out_onehot, 4'b0100);
      in_code = 2'bxx;
      tick();
      check("t3_xhold", out_onehot, 4'b0100);
      check("t3_xrdy", in_ready, 0);
      in_valid = 1'b0; in_code = 2'd0; out_ready = 1'b1;
      tick();
      check("t3_second", out_onehot, 4'b0010);
      check("t3_rdy_back", in_ready, 1);
      check("t3_cnt6", out_cnt, 6);
      tick();
      check("t3_empty", out_valid, 0);
      check("t3_cnt7", out_cnt, 7);

      // T1b async reset while FULL
      out_ready = 1'b0; in_valid = 1'b1; in_code = 2'd3;
      tick();
      in_code = 2'd0;
      tick();
      check("t1b_full", in_ready, 0);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("t1b_valid", out_valid, 0);
      check("t1b_onehot", out_onehot, 0);
      check("t1b_zero", out_zero, 0);
      check("t1b_cnt", out_cnt, 0);
      check("t1b_ready", in_ready, 1);
      rst_n = 1'b1;
      tick();
      check("t1b_after", out_valid, 0);

      // T4 toggling back-pressure with scoreboard
      for (int i = 0; i < 40; i++) begin
         in_valid = 1'b1;
         in_code = 2'($urandom_range(0, 3));
         in_zero = ($urandom_range(0, 4) == 0);
         out_ready = i[0];
         acc = in_ready;
         dlv = out_valid && out_ready;
         if (out_valid)
            check("t4_onehot_prop", ($countones(out_onehot) <= 1), 1);
         if (dlv) begin
            if (q.size() == 0) check("t4_spurious", 1, 0);
            else begin
               front = q.pop_front();
               check("t4_vec", {out_zero, out_onehot}, front);
            end
         end
         if (acc) q.push_back({in_zero, in_zero ? 4'b0000 : (4'b0001 << in_code)});
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 10 && q.size() > 0; i++) begin
         if (out_valid) begin
            front = q.pop_front();
            check("t4_drain", {out_zero, out_onehot}, front);
         end
         tick();
      end
      check("t4_left", q.size(), 0);
      check("t4_idle", out_valid, 0);

      // T5 counter wrap after 256 deliveries
      rst_n = 1'b0; #1 rst_n = 1'b1;
      in_valid = 1'b1; out_ready = 1'b1; in_zero = 1'b0;
      for (int i = 0; i < 256; i++) begin
         in_code = i[1:0];
         tick();
      end
      check("t5_cnt255", out_cnt, 255);
      in_valid = 1'b0;
      tick();
      check("t5_wrap", out_cnt, 0);
      check("t5_empty", out_valid, 0);

      // T6 loopback through a priority encoder
      out_ready = 1'b1; in_valid = 1'b1;
      for (int a = 0; a < 16; a++) begin
         e = enc(a[3:0]);
         in_code = e[1:0]; in_zero = e[2];
         tick();
         check("t6_onehot", out_onehot, top_bit(a[3:0]));
      end
      in_valid = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
